// File: rtl/ysyx_24100005_arb_pkg.sv
// Shared types and constants for the IFU/LSU data-memory arbiter.
//   - FSM state encoding, grant ids, default timeout read data
//   - packed request payload latched on grant and driven toward memory
package ysyx_24100005_arb_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned MASK_W = 8;
    localparam int unsigned WD_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam logic GNT_IFU = 1'b0;
    localparam logic GNT_LSU = 1'b1;

    localparam logic [XLEN-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic              wen;
        logic [XLEN-1:0]   wdata;
        logic [MASK_W-1:0] wmask;
    } mem_req_t;

endpackage

// File: rtl/ysyx_24100005_arb_pick.sv
// Combinational winner selection between the IFU and LSU requesters.
//   ifu_valid_i / lsu_valid_i : request valids
//   last_gnt_i                : previous winner (round-robin build only)
//   any_valid_o               : at least one requester is valid
//   gnt_o                     : winner id (GNT_IFU / GNT_LSU)
// Macro YSYX_24100005_ARB_RR_EN selects round-robin on ties; otherwise the
// LSU wins every tie.
module ysyx_24100005_arb_pick
    import ysyx_24100005_arb_pkg::*;
(
    input  logic ifu_valid_i,
    input  logic lsu_valid_i,
`ifdef YSYX_24100005_ARB_RR_EN
    input  logic last_gnt_i,
`endif
    output logic any_valid_o,
    output logic gnt_o
);

    always_comb begin
        any_valid_o = ifu_valid_i | lsu_valid_i;
        gnt_o       = lsu_valid_i ? GNT_LSU : GNT_IFU;
`ifdef YSYX_24100005_ARB_RR_EN
        // On a tie, favour whoever was not granted last.
        if (ifu_valid_i && lsu_valid_i) begin
            gnt_o = (last_gnt_i == GNT_LSU) ? GNT_IFU : GNT_LSU;
        end
`endif
    end

endmodule

// File: rtl/ysyx_24100005_mem_arbiter.sv
// Two-master (IFU, LSU) to one-slave data-memory arbiter with a single
// outstanding transaction and a response watchdog.
//   clk, rst                  : clock, async active-high reset
//   ifu_req_* / ifu_resp_*    : fetch request (read-only) and response
//   lsu_req_* / lsu_resp_*    : load/store request and response
//   mem_req_* / mem_resp_*    : request/response toward the memory model
// Parameters: TIMEOUT_CYC (1..255 WAIT cycles before abort), ERR_DATA.
// Macro YSYX_24100005_ARB_RR_EN enables round-robin tie breaking.
module ysyx_24100005_mem_arbiter
    import ysyx_24100005_arb_pkg::*;
#(
    parameter int unsigned     TIMEOUT_CYC = 255,
    parameter logic [XLEN-1:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [XLEN-1:0]   ifu_addr,
    output logic              ifu_resp_valid,
    input  logic              ifu_resp_ready,
    output logic [XLEN-1:0]   ifu_rdata,
    output logic              ifu_resp_err,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [XLEN-1:0]   lsu_addr,
    input  logic              lsu_wen,
    input  logic [XLEN-1:0]   lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_resp_valid,
    input  logic              lsu_resp_ready,
    output logic [XLEN-1:0]   lsu_rdata,
    output logic              lsu_resp_err,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_addr,
    output logic              mem_wen,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_resp_valid,
    output logic              mem_resp_ready,
    input  logic [XLEN-1:0]   mem_rdata
);

    arb_state_e        state_q, state_d;
    logic              gnt_q, gnt_d;
    mem_req_t          req_q, req_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [WD_W-1:0]   wd_q, wd_d;

    logic              any_valid;
    logic              pick_gnt;
    logic              winner_resp_ready;

`ifdef YSYX_24100005_ARB_RR_EN
    logic              last_gnt_q, last_gnt_d;
`endif

    // Winner selection
    ysyx_24100005_arb_pick u_pick (
        .ifu_valid_i (ifu_req_valid),
        .lsu_valid_i (lsu_req_valid),
`ifdef YSYX_24100005_ARB_RR_EN
        .last_gnt_i  (last_gnt_q),
`endif
        .any_valid_o (any_valid),
        .gnt_o       (pick_gnt)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= GNT_IFU;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

`ifdef YSYX_24100005_ARB_RR_EN
    // Last-grant history for round-robin ties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= GNT_LSU;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`endif

    assign winner_resp_ready = (gnt_q == GNT_LSU) ? lsu_resp_ready : ifu_resp_ready;

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wd_d    = wd_q;
`ifdef YSYX_24100005_ARB_RR_EN
        last_gnt_d = last_gnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    gnt_d = pick_gnt;
`ifdef YSYX_24100005_ARB_RR_EN
                    last_gnt_d = pick_gnt;
`endif
                    if (pick_gnt == GNT_LSU) begin
                        req_d = '{addr: lsu_addr, wen: lsu_wen, wdata: lsu_wdata, wmask: lsu_wmask};
                    end else begin
                        req_d = '{addr: ifu_addr, wen: 1'b0, wdata: '0, wmask: '0};
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    wd_d    = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    rdata_d = mem_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (wd_q == WD_W'(TIMEOUT_CYC)) begin
                    rdata_d = ERR_DATA;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            RESP: begin
                if (winner_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request ready is the only path straight from inputs; held low in reset.
    assign ifu_req_ready  = !rst && (state_q == IDLE) && any_valid && (pick_gnt == GNT_IFU);
    assign lsu_req_ready  = !rst && (state_q == IDLE) && any_valid && (pick_gnt == GNT_LSU);

    assign mem_req_valid  = (state_q == ISSUE);
    assign mem_resp_ready = (state_q == WAIT);
    assign mem_addr       = req_q.addr;
    assign mem_wen        = req_q.wen;
    assign mem_wdata      = req_q.wdata;
    assign mem_wmask      = req_q.wmask;

    assign ifu_resp_valid = (state_q == RESP) && (gnt_q == GNT_IFU);
    assign lsu_resp_valid = (state_q == RESP) && (gnt_q == GNT_LSU);
    assign ifu_resp_err   = err_q && (gnt_q == GNT_IFU);
    assign lsu_resp_err   = err_q && (gnt_q == GNT_LSU);
    assign ifu_rdata      = rdata_q;
    assign lsu_rdata      = rdata_q;

endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
// Directed, table-driven bench for the IFU/LSU memory arbiter.
module tb_ysyx_24100005_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ysyx_24100005_mem_arbiter #(.TIMEOUT_CYC(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_resp_ready (ifu_resp_ready),
        .ifu_rdata      (ifu_rdata),
        .ifu_resp_err   (ifu_resp_err),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_resp_ready (lsu_resp_ready),
        .lsu_rdata      (lsu_rdata),
        .lsu_resp_err   (lsu_resp_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_ready (mem_resp_ready),
        .mem_rdata      (mem_rdata)
    );

    typedef struct {
        logic        ifu_v;
        logic        lsu_v;
        logic [31:0] ifu_a;
        logic [31:0] lsu_a;
        logic        lsu_we;
        logic [31:0] lsu_wd;
        logic [7:0]  lsu_wm;
        logic [31:0] mem_rd;
        logic        exp_lsu;
        logic [31:0] exp_addr;
        logic        exp_wen;
        logic [31:0] exp_wdata;
        logic [7:0]  exp_wmask;
    } vec_t;

    vec_t vecs[4];

    // Tie order of three successive grants, bit i = winner of grant i (1 = LSU).
`ifdef YSYX_24100005_ARB_RR_EN
    localparam logic [2:0] TIE_ORDER = 3'b010;
`else
    localparam logic [2:0] TIE_ORDER = 3'b101;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "/ctl"}, 64'({ifu_req_ready, ifu_resp_valid, ifu_resp_err,
                                  lsu_req_ready, lsu_resp_valid, lsu_resp_err,
                                  mem_req_valid, mem_wen, mem_resp_ready, mem_wmask}), 64'd0);
        check({tag, "/rdata"}, {ifu_rdata, lsu_rdata}, 64'd0);
        check({tag, "/mem_payload"}, {mem_addr, mem_wdata}, 64'd0);
    endtask

    // Enter just after a rising edge in IDLE with requests driven; leaves at
    // the same phase back in IDLE. Memory answers immediately.
    task automatic txn(input logic exp_lsu, input logic [31:0] e_addr, input logic e_wen,
                       input logic [31:0] e_wdata, input logic [7:0] e_wmask,
                       input logic [31:0] e_rdata, input string tag);
        @(negedge clk);
        check({tag, "/grant"}, 64'({ifu_req_ready, lsu_req_ready}), 64'({!exp_lsu, exp_lsu}));
        @(posedge clk); #1;
        if (exp_lsu) lsu_req_valid = 1'b0;
        else         ifu_req_valid = 1'b0;
        @(negedge clk);
        check({tag, "/issue_ctl"}, 64'({mem_req_valid, mem_wen, ifu_req_ready, lsu_req_ready}),
              64'({1'b1, e_wen, 1'b0, 1'b0}));
        check({tag, "/issue_addr"}, 64'(mem_addr), 64'(e_addr));
        check({tag, "/issue_wd"}, 64'({mem_wdata, mem_wmask}), 64'({e_wdata, e_wmask}));
        @(posedge clk);
        @(negedge clk);
        check({tag, "/wait"}, 64'({mem_resp_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid}),
              64'b1000);
        @(posedge clk);
        @(negedge clk);
        check({tag, "/resp_valid"}, 64'({ifu_resp_valid, lsu_resp_valid}), 64'({!exp_lsu, exp_lsu}));
        check({tag, "/resp_data"},
              exp_lsu ? 64'({lsu_rdata, lsu_resp_err}) : 64'({ifu_rdata, ifu_resp_err}),
              64'({e_rdata, 1'b0}));
        @(posedge clk); #1;
    endtask

    initial begin
        int  waits;
        logic got;
        logic exp_l;

        vecs[0] = '{ifu_v: 1'b1, lsu_v: 1'b0, ifu_a: 32'h8000_0000, lsu_a: 32'h0, lsu_we: 1'b0,
                    lsu_wd: 32'h0, lsu_wm: 8'h00, mem_rd: 32'h0000_0413, exp_lsu: 1'b0,
                    exp_addr: 32'h8000_0000, exp_wen: 1'b0, exp_wdata: 32'h0, exp_wmask: 8'h00};
        vecs[1] = '{ifu_v: 1'b0, lsu_v: 1'b1, ifu_a: 32'h0, lsu_a: 32'h8000_1000, lsu_we: 1'b1,
                    lsu_wd: 32'h1234_5678, lsu_wm: 8'h0F, mem_rd: 32'h0000_0000, exp_lsu: 1'b1,
                    exp_addr: 32'h8000_1000, exp_wen: 1'b1, exp_wdata: 32'h1234_5678, exp_wmask: 8'h0F};
        vecs[2] = '{ifu_v: 1'b0, lsu_v: 1'b1, ifu_a: 32'h0, lsu_a: 32'h8000_2004, lsu_we: 1'b0,
                    lsu_wd: 32'h0000_0000, lsu_wm: 8'h03, mem_rd: 32'hCAFE_F00D, exp_lsu: 1'b1,
                    exp_addr: 32'h8000_2004, exp_wen: 1'b0, exp_wdata: 32'h0, exp_wmask: 8'h03};
        // IFU request while idle LSU payload pins carry junk: IFU fields zeroed
        vecs[3] = '{ifu_v: 1'b1, lsu_v: 1'b0, ifu_a: 32'h8000_0004, lsu_a: 32'hFFFF_FFF0, lsu_we: 1'b1,
                    lsu_wd: 32'hFFFF_FFFF, lsu_wm: 8'hFF, mem_rd: 32'h00A0_0093, exp_lsu: 1'b0,
                    exp_addr: 32'h8000_0004, exp_wen: 1'b0, exp_wdata: 32'h0, exp_wmask: 8'h00};

        rst = 1'b1;
        ifu_req_valid = 1'b0; ifu_addr = '0; ifu_resp_ready = 1'b1;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        lsu_resp_ready = 1'b1;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = '0;

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Single-requester vectors
        for (int i = 0; i < 4; i++) begin
            ifu_req_valid = vecs[i].ifu_v; ifu_addr = vecs[i].ifu_a;
            lsu_req_valid = vecs[i].lsu_v; lsu_addr = vecs[i].lsu_a; lsu_wen = vecs[i].lsu_we;
            lsu_wdata = vecs[i].lsu_wd; lsu_wmask = vecs[i].lsu_wm;
            mem_rdata = vecs[i].mem_rd;
            txn(vecs[i].exp_lsu, vecs[i].exp_addr, vecs[i].exp_wen, vecs[i].exp_wdata,
                vecs[i].exp_wmask, vecs[i].mem_rd, $sformatf("vec%0d", i));
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

        // Ties start from reset so the round-robin history is known
        rst = 1'b1; #2; rst = 1'b0;
        ifu_addr = 32'h8000_0100;
        lsu_addr = 32'h8000_0200; lsu_wen = 1'b0; lsu_wdata = 32'h0000_0011; lsu_wmask = 8'h0F;
        for (int g = 0; g < 3; g++) begin
            if (g != 1) begin
                ifu_req_valid = 1'b1;
                lsu_req_valid = 1'b1;
            end
            exp_l = TIE_ORDER[g];
            mem_rdata = 32'h7100_0000 + 32'(g);
            if (exp_l)
                txn(1'b1, 32'h8000_0200, 1'b0, 32'h0000_0011, 8'h0F, mem_rdata, $sformatf("tie%0d", g));
            else
                txn(1'b0, 32'h8000_0100, 1'b0, 32'h0, 8'h00, mem_rdata, $sformatf("tie%0d", g));
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

        // Watchdog: memory never answers
        mem_resp_valid = 1'b0;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010;
        @(negedge clk);
        check("timeout/grant", 64'(ifu_req_ready), 64'd1);
        @(posedge clk); #1;
        ifu_req_valid = 1'b0;
        @(posedge clk);
        waits = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ifu_resp_valid) got = 1'b1;
            else begin
                if (mem_resp_ready) waits++;
                @(posedge clk);
            end
        end
        check("timeout/seen", 64'(got), 64'd1);
        check("timeout/wait_cycles", 64'(waits), 64'd9);
        check("timeout/resp", 64'({ifu_rdata, ifu_resp_err, lsu_resp_valid}), 64'({32'hDEAD_BEEF, 1'b1, 1'b0}));
        @(posedge clk); #1;
        mem_resp_valid = 1'b1;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0020; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 8'h00;
        mem_rdata = 32'h1111_2222;
        txn(1'b1, 32'h8000_0020, 1'b0, 32'h0, 8'h00, 32'h1111_2222, "after_timeout");

        // Backpressure on both the memory request and the LSU response
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1008; lsu_wen = 1'b1;
        lsu_wdata = 32'hA5A5_5A5A; lsu_wmask = 8'hF0;
        mem_req_ready = 1'b0; lsu_resp_ready = 1'b0; mem_rdata = 32'h600D_0001;
        @(negedge clk);
        check("bp/grant", 64'({ifu_req_ready, lsu_req_ready}), 64'b01);
        @(posedge clk); #1;
        lsu_req_valid = 1'b0;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0008;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp/issue%0d_ctl", i),
                  64'({mem_req_valid, mem_wen, ifu_req_ready, lsu_req_ready, mem_wmask}),
                  64'({1'b1, 1'b1, 1'b0, 1'b0, 8'hF0}));
            check($sformatf("bp/issue%0d_payload", i), {mem_addr, mem_wdata}, {32'h8000_1008, 32'hA5A5_5A5A});
            @(posedge clk); #1;
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        check("bp/issue_release", 64'(mem_req_valid), 64'd1);
        @(posedge clk);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bp/resp%0d", i),
                  64'({lsu_resp_valid, lsu_rdata, lsu_resp_err, ifu_req_ready, ifu_resp_valid}),
                  64'({1'b1, 32'h600D_0001, 1'b0, 1'b0, 1'b0}));
            @(posedge clk);
        end
        #1;
        lsu_resp_ready = 1'b1;
        @(negedge clk);
        check("bp/resp_final", 64'(lsu_resp_valid), 64'd1);
        @(posedge clk); #1;
        mem_rdata = 32'h600D_0002;
        txn(1'b0, 32'h8000_0008, 1'b0, 32'h0, 8'h00, 32'h600D_0002, "bp_ifu");

        // Reset asserted while waiting on memory
        mem_resp_valid = 1'b0;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0300;
        @(negedge clk);
        @(posedge clk); #1;
        ifu_req_valid = 1'b0;
        @(posedge clk); #1;
        check("midrst/in_wait", 64'(mem_resp_ready), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        mem_resp_valid = 1'b1;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0400; mem_rdata = 32'h0000_0093;
        txn(1'b0, 32'h8000_0400, 1'b0, 32'h0, 8'h00, 32'h0000_0093, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_24100005_mem_arbiter.md
# ysyx_24100005_mem_arbiter

Two-master, one-slave arbiter for the single NPC data memory port. The IFU (instruction fetch) and LSU (load/store) share one memory interface, which is backed by the DPI `npcmem_read`/`npcmem_write` model. The block serialises their requests through a registered FSM with a single outstanding transaction, and returns each response to the requester that issued it. A watchdog aborts memory transactions that hang.

## Interface
Parameters:
- `TIMEOUT_CYC`, 255: cycles allowed in WAIT before abort; range 1..255 (8-bit counter).
- `ERR_DATA`, 32'hDEAD_BEEF: rdata returned on timeout.

Ports:
- `clk` in 1: single clock; all state on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ifu_req_valid` in 1 / `ifu_req_ready` out 1 / `ifu_addr` in 32: fetch request; always a read.
- `ifu_resp_valid` out 1 / `ifu_resp_ready` in 1 / `ifu_rdata` out 32 / `ifu_resp_err` out 1: fetch response.
- `lsu_req_valid` in 1 / `lsu_req_ready` out 1: LSU request handshake.
- `lsu_addr` in 32 / `lsu_wen` in 1 / `lsu_wdata` in 32 / `lsu_wmask` in 8: LSU request payload; `wmask` matches the DPI byte mask.
- `lsu_resp_valid` out 1 / `lsu_resp_ready` in 1 / `lsu_rdata` out 32 / `lsu_resp_err` out 1: LSU response; also returned for stores.
- `mem_req_valid` out 1 / `mem_req_ready` in 1: request handshake toward memory.
- `mem_addr` out 32 / `mem_wen` out 1 / `mem_wdata` out 32 / `mem_wmask` out 8: request payload toward memory.
- `mem_resp_valid` in 1 / `mem_resp_ready` out 1 / `mem_rdata` in 32: response from memory.

## Operation
- States:
  - IDLE: accept a request.
  - ISSUE: present it to memory.
  - WAIT: collect the memory response.
  - RESP: return the response to the winner.
- IDLE:
  - If any `*_req_valid` is high, pick a winner and assert that winner's `*_req_ready` combinationally in the same cycle.
  - Latch addr, wen, wdata, wmask and the winner id; go to ISSUE.
  - IFU fields are latched as wen=0, wmask=0, wdata=0.
- Selection: fixed priority (LSU > IFU), or round-robin when configured (see Configuration).
- ISSUE: `mem_req_valid`=1 with the latched fields. Payload is stable until `mem_req_ready`; on handshake go to WAIT and clear the watchdog.
- WAIT:
  - `mem_resp_ready`=1.
  - On `mem_resp_valid`, latch `mem_rdata`, set err=0 and go to RESP.
  - Otherwise increment the watchdog. When it reaches `TIMEOUT_CYC`, latch `ERR_DATA`, set err=1 and go to RESP.
- RESP:
  - Assert the winner's `*_resp_valid` with the latched rdata/err; the non-winner's resp_valid stays 0.
  - On `*_resp_ready`, go to IDLE.
- Req_ready is 0 in every state except IDLE, so at most one transaction is outstanding.
- A memory response arriving outside WAIT is ignored (`mem_resp_ready`=0).
- Boundary cases:
  - Simultaneous requests: exactly one is granted; the loser keeps valid asserted and is served next.
  - A requester dropping valid before ready is legal; nothing is latched.
  - Reset mid-transaction: FSM returns to IDLE and the outstanding transaction is dropped silently.

## Timing
- Reset values: state=IDLE; all `*_ready`, `*_valid` and err outputs 0; rdata and mem payload outputs 0; watchdog 0; last-grant=LSU.
- Minimum latency, request handshake to resp_valid: 3 cycles (IDLE→ISSUE→WAIT→RESP), with memory ready and responding immediately.
- Back-to-back throughput: one transaction per 4 cycles.
- Every output is a register or a pure decode of state, except `*_req_ready`, which is gated by valid in IDLE.
- Timeout response appears `TIMEOUT_CYC`+1 cycles after entering WAIT.

## Configuration
- `YSYX_24100005_ARB_RR_EN` defined: round-robin selection.
  - On a tie, grant the requester not granted last.
  - The last-grant register updates on each grant.
  - Reset value is LSU, so the first tie goes to IFU.
- Undefined: fixed priority, LSU always wins ties. The last-grant register is not built.

## Structure
- Package `ysyx_24100005_arb_pkg`:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3);
  - grant id constants (GNT_IFU=1'b0, GNT_LSU=1'b1);
  - default `ERR_DATA`.
- One sub-module, `ysyx_24100005_arb_pick`: combinational winner selection from the two valids and last-grant. This is the only place the RR macro applies.
- FSM, payload latches and watchdog live in the top arbiter.

## Test plan
- IFU-only read: addr 0x8000_0000, memory returns 0x0000_0413 immediately → `ifu_resp_valid` 3 cycles after handshake, rdata 0x0000_0413, err 0; LSU outputs stay idle.
- LSU store: addr 0x8000_1000, wdata 0x1234_5678, wmask 8'h0F → mem sees wen=1 with identical payload; `lsu_resp_valid` follows.
- Simultaneous IFU+LSU valids:
  - Fixed build → LSU served first, IFU second.
  - RR build → IFU first, then LSU, then IFU on a repeated tie.
- Memory never asserts `mem_resp_valid`, `TIMEOUT_CYC`=8 → resp_valid with rdata 0xDEAD_BEEF and err=1 after 9 WAIT cycles; next request proceeds normally.
- Backpressure: `mem_req_ready` low 5 cycles and `lsu_resp_ready` low 3 cycles → payload and resp outputs held stable throughout; no second grant.
- Assert `rst` while in WAIT → all outputs 0 asynchronously; after release, a new IFU request completes correctly.
